ccd_bank: RTL and testbench

Multi-channel, windowed successor to the single-channel correlation-sign detector. One reference bit stream `x1_k` gates edge events on `CHANNELS` comparison streams. Each channel keeps a saturating signed up/down accumulator: up on a qualified rising edge, down on a qualified falling edge. Accumulators are dumped and restarted at the end of a programmable integration window. The block sits between the sample front end and the lock/decision logic, and replaces externally delayed edge inputs with internal edge detection.

---
 rtl/ccd_bank.sv | 146 ++++++++++++++
 tb/tb_ccd_bank.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/ccd_bank.sv
// Multi-channel correlation-sign detector: a reference bit qualifies edges on each
// comparison stream, which drive saturating up/down accumulators dumped per window.
module ccd_bank #(
  parameter int WIDTH    = 19,
  parameter int CHANNELS = 4,
  parameter int LEN_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      clear,
  input  logic                      x1_k,
  input  logic [CHANNELS-1:0]       x2_k,
  input  logic [LEN_W-1:0]          win_len,
  output logic [CHANNELS*WIDTH-1:0] acc_out,
  output logic [CHANNELS-1:0]       sign_out,
  output logic [CHANNELS-1:0]       sat_out,
  output logic                      dump_valid
);

  localparam logic signed [WIDTH-1:0] ACC_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] ACC_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [WIDTH-1:0] ONE     = WIDTH'(1);

  logic signed [WIDTH-1:0] acc_q [CHANNELS];
  logic signed [WIDTH-1:0] acc_d [CHANNELS];
  logic signed [WIDTH-1:0] acc_nxt [CHANNELS];
  logic [CHANNELS-1:0]       sat_q, sat_d, sat_nxt;
  logic [CHANNELS-1:0]       x2_prev_q, x2_prev_d;
  logic                      primed_q, primed_d;
  logic [LEN_W-1:0]          cnt_q, cnt_d, cnt_inc;
  logic [LEN_W-1:0]          len_q, len_d, eff_len;
  logic [CHANNELS*WIDTH-1:0] acc_out_q, acc_out_d, acc_pack;
  logic [CHANNELS-1:0]       sat_out_q, sat_out_d;
  logic                      dump_valid_q, dump_valid_d;

  // Returns {blocked, next value}; a request at the matching limit is blocked, never wrapped.
  function automatic logic [WIDTH:0] sat_step(input logic signed [WIDTH-1:0] a,
                                              input logic up, input logic dn);
    logic                    blk;
    logic signed [WIDTH-1:0] r;
    blk = 1'b0;
    r   = a;
    if (up) begin
      if (a == ACC_MAX) blk = 1'b1;
      else              r   = a + ONE;
    end else if (dn) begin
      if (a == ACC_MIN) blk = 1'b1;
      else              r   = a - ONE;
    end
    return {blk, r};
  endfunction

  always_comb begin
    logic [WIDTH:0] st;
    logic           up, dn;
    sat_nxt  = sat_q;
    acc_pack = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      up = primed_q & x1_k &  x2_k[i] & ~x2_prev_q[i];
      dn = primed_q & x1_k & ~x2_k[i] &  x2_prev_q[i];
      st = sat_step(acc_q[i], up, dn);
      acc_nxt[i] = st[WIDTH-1:0];
      if (st[WIDTH]) sat_nxt[i] = 1'b1;
      acc_pack[i*WIDTH +: WIDTH] = st[WIDTH-1:0];
    end
  end

  // The first sample of a window uses the live length, later samples the captured one.
  assign eff_len = (cnt_q == '0) ? win_len : len_q;
  assign cnt_inc = cnt_q + LEN_W'(1);

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) acc_d[i] = acc_q[i];
    sat_d        = sat_q;
    x2_prev_d    = x2_prev_q;
    primed_d     = primed_q;
    cnt_d        = cnt_q;
    len_d        = len_q;
    acc_out_d    = acc_out_q;
    sat_out_d    = sat_out_q;
    dump_valid_d = 1'b0;
    if (clear) begin
      for (int i = 0; i < CHANNELS; i++) acc_d[i] = '0;
      sat_d    = '0;
      cnt_d    = '0;
      primed_d = 1'b0;
    end else if (en) begin
      len_d     = eff_len;
      x2_prev_d = x2_k;
      primed_d  = 1'b1;
      if (eff_len == '0) begin
        // Free-running: counter parked non-zero so the length is never recaptured.
        for (int i = 0; i < CHANNELS; i++) acc_d[i] = acc_nxt[i];
        sat_d     = sat_nxt;
        cnt_d     = LEN_W'(1);
        acc_out_d = acc_pack;
        sat_out_d = sat_nxt;
      end else if (cnt_inc == eff_len) begin
        for (int i = 0; i < CHANNELS; i++) acc_d[i] = '0;
        sat_d        = '0;
        cnt_d        = '0;
        acc_out_d    = acc_pack;
        sat_out_d    = sat_nxt;
        dump_valid_d = 1'b1;
      end else begin
        for (int i = 0; i < CHANNELS; i++) acc_d[i] = acc_nxt[i];
        sat_d = sat_nxt;
        cnt_d = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) acc_q[i] <= '0;
      sat_q        <= '0;
      x2_prev_q    <= '0;
      primed_q     <= 1'b0;
      cnt_q        <= '0;
      len_q        <= '0;
      acc_out_q    <= '0;
      sat_out_q    <= '0;
      dump_valid_q <= 1'b0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) acc_q[i] <= acc_d[i];
      sat_q        <= sat_d;
      x2_prev_q    <= x2_prev_d;
      primed_q     <= primed_d;
      cnt_q        <= cnt_d;
      len_q        <= len_d;
      acc_out_q    <= acc_out_d;
      sat_out_q    <= sat_out_d;
      dump_valid_q <= dump_valid_d;
    end
  end

  assign acc_out    = acc_out_q;
  assign sat_out    = sat_out_q;
  assign dump_valid = dump_valid_q;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_sign
    assign sign_out[g] = acc_out_q[g*WIDTH + WIDTH - 1];
  end

endmodule

// File: tb/tb_ccd_bank.sv
// Bench for ccd_bank: directed scenarios plus random traffic against a sample-level model.
module tb_ccd_bank;
  localparam int W  = 4;
  localparam int CH = 4;
  localparam int LW = 8;
  localparam int AMAX = (1 << (W-1)) - 1;
  localparam int AMIN = -(1 << (W-1));

  logic            clk = 0;
  logic            rst, en, clear, x1_k;
  logic [CH-1:0]   x2_k;
  logic [LW-1:0]   win_len;
  logic [CH*W-1:0] acc_out;
  logic [CH-1:0]   sign_out, sat_out;
  logic            dump_valid;

  ccd_bank #(.WIDTH(W), .CHANNELS(CH), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst), .en(en), .clear(clear), .x1_k(x1_k), .x2_k(x2_k),
    .win_len(win_len), .acc_out(acc_out), .sign_out(sign_out), .sat_out(sat_out),
    .dump_valid(dump_valid));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: sample-level description of the detector.
  int macc [CH];
  bit msat [CH];
  bit mprev[CH];
  bit mprimed;
  int mcnt, mlen;
  int eacc [CH];
  bit esat [CH];
  bit edv;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int acc_ch(input int c);
    logic [W-1:0] v;
    v = acc_out[c*W +: W];
    return int'($signed(v));
  endfunction

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      macc[c] = 0; msat[c] = 0; mprev[c] = 0; eacc[c] = 0; esat[c] = 0;
    end
    mprimed = 0; mcnt = 0; mlen = 0; edv = 0;
  endtask

  task automatic check_all(input string tag);
    for (int c = 0; c < CH; c++) begin
      chk($sformatf("%s acc%0d", tag, c), acc_ch(c), eacc[c]);
      chk($sformatf("%s sign%0d", tag, c), int'(sign_out[c]), int'(eacc[c] < 0));
      chk($sformatf("%s sat%0d", tag, c), int'(sat_out[c]), int'(esat[c]));
    end
    chk($sformatf("%s dv", tag), int'(dump_valid), int'(edv));
  endtask

  task automatic do_reset();
    rst = 1; en = 0; clear = 0; x1_k = 0; x2_k = '0; win_len = '0;
    @(posedge clk); #1;
    rst = 0;
    model_reset();
    check_all("reset");
  endtask

  // One clock with the given inputs; model advances, outputs checked after the edge.
  task automatic step(input bit e, input bit clr, input bit x1, input logic [CH-1:0] x2,
                      input int wl, input string tag);
    en = e; clear = clr; x1_k = x1; x2_k = x2; win_len = LW'(wl);
    @(posedge clk);
    edv = 0;
    if (clr) begin
      for (int c = 0; c < CH; c++) begin macc[c] = 0; msat[c] = 0; end
      mcnt = 0; mprimed = 0;
    end else if (e) begin
      if (mcnt == 0) mlen = wl;
      for (int c = 0; c < CH; c++) begin
        if (mprimed && x1 && x2[c] && !mprev[c]) begin
          if (macc[c] == AMAX) msat[c] = 1; else macc[c] += 1;
        end
        if (mprimed && x1 && !x2[c] && mprev[c]) begin
          if (macc[c] == AMIN) msat[c] = 1; else macc[c] -= 1;
        end
        mprev[c] = x2[c];
      end
      mprimed = 1;
      mcnt++;
      if (mlen == 0) begin
        for (int c = 0; c < CH; c++) begin eacc[c] = macc[c]; esat[c] = msat[c]; end
      end else if (mcnt == mlen) begin
        edv = 1;
        for (int c = 0; c < CH; c++) begin
          eacc[c] = macc[c]; esat[c] = msat[c]; macc[c] = 0; msat[c] = 0;
        end
        mcnt = 0;
      end
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [CH-1:0] pat;
    int wl;
    do_reset();

    // Basic window: 0,1,0,1 on ch0 -> prime, rise, fall, rise = +1.
    pat = 4'b0000; step(1, 0, 1, pat, 4, "w4s1");
    pat = 4'b0001; step(1, 0, 1, pat, 4, "w4s2");
    pat = 4'b0000; step(1, 0, 1, pat, 4, "w4s3");
    pat = 4'b0001; step(1, 0, 1, pat, 4, "w4s4");
    chk("basic_acc0", acc_ch(0), 1);
    chk("basic_dv", int'(dump_valid), 1);
    chk("basic_sign0", int'(sign_out[0]), 0);
    step(0, 0, 1, pat, 4, "idle");
    chk("dv_one_pulse", int'(dump_valid), 0);

    // Reference low: edges never qualified.
    for (int s = 0; s < 8; s++) step(1, 0, 0, (s % 2) ? 4'b1111 : 4'b0000, 4, "x1low");
    chk("x1low_acc0", acc_ch(0), 0);

    // Free-running saturation on ch1: only falling edges qualified.
    for (int s = 0; s < 10; s++) begin
      step(1, 0, 0, 4'b0010, 0, "fr_up");
      step(1, 0, 1, 4'b0000, 0, "fr_dn");
    end
    chk("fr_acc1", acc_ch(1), AMIN);
    chk("fr_sat1", int'(sat_out[1]), 1);
    chk("fr_sign1", int'(sign_out[1]), 1);
    chk("fr_dv", int'(dump_valid), 0);

    // Clear mid-window.
    step(1, 1, 1, 4'b0000, 4, "clr_exit");
    pat = 4'b0000; step(1, 0, 1, pat, 4, "c1");
    pat = 4'b0100; step(1, 0, 1, pat, 4, "c2");
    step(1, 0, 1, 4'b0000, 4, "c3");
    step(1, 1, 1, 4'b0100, 4, "c_clr");
    chk("clr_hold_acc1", acc_ch(1), AMIN);
    for (int s = 0; s < 4; s++) step(1, 0, 1, (s % 2) ? 4'b0100 : 4'b0000, 4, "c_after");
    chk("clr_full_window_dv", int'(dump_valid), 1);

    // Length change mid-window 8 -> 3.
    for (int s = 0; s < 8; s++) step(1, 0, 1, 4'(s), (s < 3) ? 8 : 3, "len8");
    chk("len8_dv", int'(dump_valid), 1);
    for (int s = 0; s < 3; s++) step(1, 0, 1, 4'(s + 5), 3, "len3");
    chk("len3_dv", int'(dump_valid), 1);

    // Edge spanning a window boundary.
    step(1, 0, 1, 4'b0000, 2, "span1");
    step(1, 0, 1, 4'b0000, 2, "span2");
    step(1, 0, 1, 4'b1000, 2, "span3");
    step(1, 0, 1, 4'b1000, 2, "span4");
    chk("span_acc3", acc_ch(3), 1);

    // Length 1 with en held: dump every sample.
    for (int s = 0; s < 4; s++) step(1, 0, 1, 4'(s * 5), 1, "len1");

    // Reset mid-window discards the window.
    step(1, 0, 1, 4'b0000, 5, "pre_rst1");
    step(1, 0, 1, 4'b1111, 5, "pre_rst2");
    do_reset();

    // Random traffic.
    wl = 3;
    for (int s = 0; s < 1500; s++) begin
      if ($urandom_range(0, 29) == 0) wl = $urandom_range(0, 6);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0,
           4'($urandom), wl, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
